// File: rtl/font_rom.sv
// Synchronous 8x16 glyph ROM for the VGA text path. The address register is
// followed by a combinational table; only digits '0'-'9' and ':' are populated.
module font_rom (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  // Each glyph is 16 rows packed MSB-first: row 0 (top) is bits [127:120].
  localparam logic [127:0] GLYPH_0     = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
  localparam logic [127:0] GLYPH_1     = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
  localparam logic [127:0] GLYPH_2     = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
  localparam logic [127:0] GLYPH_3     = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
  localparam logic [127:0] GLYPH_4     = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
  localparam logic [127:0] GLYPH_5     = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
  localparam logic [127:0] GLYPH_6     = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
  localparam logic [127:0] GLYPH_7     = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
  localparam logic [127:0] GLYPH_8     = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
  localparam logic [127:0] GLYPH_9     = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
  localparam logic [127:0] GLYPH_COLON = 128'h0000_0000_1818_0000_0018_1800_0000_0000;

  logic [10:0]  addr_q;
  logic [10:0]  addr_d;
  logic [6:0]   code;
  logic [3:0]   row;
  logic [127:0] glyph;

  assign addr_d = addr;

  always_ff @(posedge clk) begin
    if (reset) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  assign code = addr_q[10:4];
  assign row  = addr_q[3:0];

  always_comb begin
    glyph = '0;
    case (code)
      7'h30:   glyph = GLYPH_0;
      7'h31:   glyph = GLYPH_1;
      7'h32:   glyph = GLYPH_2;
      7'h33:   glyph = GLYPH_3;
      7'h34:   glyph = GLYPH_4;
      7'h35:   glyph = GLYPH_5;
      7'h36:   glyph = GLYPH_6;
      7'h37:   glyph = GLYPH_7;
      7'h38:   glyph = GLYPH_8;
      7'h39:   glyph = GLYPH_9;
      7'h3A:   glyph = GLYPH_COLON;
      default: glyph = '0;
    endcase
  end

  // Row 0 sits in the top byte, so the byte offset is (15 - row) * 8.
  assign data = glyph[{~row, 3'b000} +: 8];

endmodule

// File: tb/tb_font_rom.sv
// Self-checking bench for font_rom: directed scenarios plus a randomized run
// against a byte-table reference model of the glyph font.
module tb_font_rom;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] addr = '0;
  logic [7:0]  data;

  int n_cmp = 0;
  int n_bad = 0;

  font_rom dut (.clk(clk), .reset(reset), .addr(addr), .data(data));

  always #5 clk = ~clk;

  // Reference font, one byte per row, glyphs for codes 0x30..0x3A.
  logic [7:0] glyphs [11][16] = '{
    '{8'h00,8'h00,8'h7C,8'hC6,8'hC6,8'hCE,8'hDE,8'hF6,8'hE6,8'hC6,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h18,8'h38,8'h78,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h7E,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h7C,8'hC6,8'h06,8'h0C,8'h18,8'h30,8'h60,8'hC0,8'hC6,8'hFE,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h7C,8'hC6,8'h06,8'h06,8'h3C,8'h06,8'h06,8'h06,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h0C,8'h1C,8'h3C,8'h6C,8'hCC,8'hFE,8'h0C,8'h0C,8'h0C,8'h1E,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'hFE,8'hC0,8'hC0,8'hC0,8'hFC,8'h06,8'h06,8'h06,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h38,8'h60,8'hC0,8'hC0,8'hFC,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'hFE,8'hC6,8'h06,8'h06,8'h0C,8'h18,8'h30,8'h30,8'h30,8'h30,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h7C,8'hC6,8'hC6,8'hC6,8'h7C,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h7C,8'hC6,8'hC6,8'hC6,8'h7E,8'h06,8'h06,8'h06,8'h0C,8'h78,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h00,8'h00,8'h18,8'h18,8'h00,8'h00,8'h00,8'h18,8'h18,8'h00,8'h00,8'h00,8'h00,8'h00}
  };

  function automatic logic [7:0] ref_rom(input logic [10:0] a);
    int code, row;
    code = int'(a) / 16;
    row  = int'(a) % 16;
    if (code >= 'h30 && code <= 'h3A) return glyphs[code - 'h30][row];
    return 8'h00;
  endfunction

  // Present inputs on the falling edge, then sample just after the next rising edge.
  task automatic tick(input logic [10:0] a, input logic r);
    @(negedge clk);
    addr  = a;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      tick(11'h305, 1'b1);
      n_cmp++;
      if (data !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: got %h want 00", i, data);
      end
    end
    tick(11'h305, 1'b0);
    n_cmp++;
    if (data !== 8'hCE) begin
      n_bad++;
      $display("FAIL reset_release: got %h want ce", data);
    end
  endtask

  task automatic test_latency;
    tick(11'h306, 1'b0);
    n_cmp++;
    if (data !== 8'hDE) begin
      n_bad++;
      $display("FAIL latency_first: got %h want de", data);
    end
    // New address is visible on the input but must not reach data before the edge.
    @(negedge clk);
    addr = 11'h000;
    #2;
    n_cmp++;
    if (data !== 8'hDE) begin
      n_bad++;
      $display("FAIL latency_hold: got %h want de", data);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (data !== 8'h00) begin
      n_bad++;
      $display("FAIL latency_next: got %h want 00", data);
    end
  endtask

  task automatic test_glyph_one;
    logic [7:0] want [16] = '{8'h00,8'h00,8'h18,8'h38,8'h78,8'h18,8'h18,8'h18,
                              8'h18,8'h18,8'h18,8'h7E,8'h00,8'h00,8'h00,8'h00};
    for (int r = 0; r < 16; r++) begin
      tick(11'h310 + 11'(r), 1'b0);
      n_cmp++;
      if (data !== want[r]) begin
        n_bad++;
        $display("FAIL glyph_one row %0d: got %h want %h", r, data, want[r]);
      end
    end
  endtask

  task automatic test_colon_blank;
    logic [10:0] a_tab [4] = '{11'h3A4, 11'h3A6, 11'h205, 11'h415};
    logic [7:0]  d_tab [4] = '{8'h18,   8'h00,   8'h00,   8'h00};
    for (int i = 0; i < 4; i++) begin
      tick(a_tab[i], 1'b0);
      n_cmp++;
      if (data !== d_tab[i]) begin
        n_bad++;
        $display("FAIL colon_blank addr %h: got %h want %h", a_tab[i], data, d_tab[i]);
      end
    end
  endtask

  task automatic test_sweep;
    int bad_here = 0;
    for (int i = 0; i <= 2049; i++) begin
      logic [10:0] a;
      a = 11'(i);
      tick(a, 1'b0);
      n_cmp++;
      if (data !== ref_rom(a)) begin
        n_bad++;
        bad_here++;
        if (bad_here <= 10)
          $display("FAIL sweep addr %h: got %h want %h", a, data, ref_rom(a));
      end
    end
  endtask

  task automatic test_mid_reset;
    for (int i = 'h380; i < 'h390; i++) begin
      logic [10:0] a;
      logic        r;
      logic [7:0]  w;
      a = 11'(i);
      r = (i == 'h386);
      w = r ? 8'h00 : ref_rom(a);
      tick(a, r);
      n_cmp++;
      if (data !== w) begin
        n_bad++;
        $display("FAIL mid_reset addr %h rst %0b: got %h want %h", a, r, data, w);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      logic [10:0] a;
      logic        r;
      logic [7:0]  w;
      // Bias toward the populated region so glyph rows get real coverage.
      if ($urandom_range(1, 0) == 1) a = 11'h300 + 11'($urandom_range(175, 0));
      else                           a = 11'($urandom_range(2047, 0));
      r = ($urandom_range(15, 0) == 0);
      w = r ? 8'h00 : ref_rom(a);
      tick(a, r);
      n_cmp++;
      if (data !== w) begin
        n_bad++;
        $display("FAIL random[%0d] addr %h rst %0b: got %h want %h", i, a, r, data, w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glyph_one();
    test_colon_blank();
    test_sweep();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
